// File: rtl/data_mem_stage.sv
// MEM-stage data memory controller: LDUR/STUR (8-byte) and LDURB/STURB
// (1-byte) accesses to an internal little-endian byte memory with a fixed
// multi-cycle latency. memStall freezes the upstream pipeline until the
// access completes.
//
// Timing: the request cycle (IDLE) is the first stall cycle. BUSY covers the
// remaining LATENCY-1 stall cycles, and the access commits at the rising edge
// that ends the last BUSY cycle. DONE is the single non-stalled cycle in which
// memDataOut/memErr are valid. With LATENCY=2 a request therefore sees
// IDLE(stall) -> BUSY(stall) -> DONE. BUSY always lasts at least one cycle,
// so LATENCY=1 behaves like LATENCY=2.
module data_mem_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_MEM,
  input  logic        memWrite_MEM,
  input  logic        xferByte_MEM,
  input  logic [63:0] address_MEM,
  input  logic [63:0] storeData_MEM,
  output logic [63:0] memDataOut,
  output logic        memStall,
  output logic        memErr
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Decoded view of the request held on the EX/MEM register
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          byte_acc;
    logic [AW-1:0] idx;
    logic          err;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;

  logic [7:0]    mem [MEM_BYTES];

  req_t          req;
  logic          req_vld;
  logic          commit;
  logic          st_en;
  logic [AW-1:0] base_idx;
  logic [63:0]   rd_word;

  // Request decode and the three illegal-access conditions
  always_comb begin
    req          = '0;
    req.rd       = memRead_MEM;
    req.wr       = memWrite_MEM;
    req.byte_acc = xferByte_MEM;
    req.idx      = address_MEM[AW-1:0];
    // An 8-byte access must be naturally aligned; once aligned it can never
    // straddle the top of memory, so the range check reduces to "no address
    // bits set above the memory index".
    req.err      = (!xferByte_MEM && (address_MEM[2:0] != 3'b000))
                 || ((address_MEM >> AW) != 64'd0)
                 || (memRead_MEM && memWrite_MEM);
  end

  assign req_vld  = memRead_MEM | memWrite_MEM;
  assign base_idx = req.idx & ~AW'(7);
  assign commit   = (state_q == BUSY) && (cnt_q <= CW'(1));
  // A reset sampled on the commit edge cancels the write.
  assign st_en    = commit && req.wr && !req.err && !reset;

  // Little-endian 8-byte read of the aligned word containing the address
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base_idx | AW'(i)];
    end
  end

  // Next-state logic and stall generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memStall = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          memStall = 1'b1;
          state_d  = BUSY;
          cnt_d    = CW'(LATENCY - 1);
        end
      end
      BUSY: begin
        memStall = 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // The request is still on the inputs here but is not re-accepted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load-data / error result produced at the commit edge
  always_comb begin
    data_d = data_q;
    err_d  = 1'b0;
    if (commit) begin
      if (req.err) begin
        data_d = '0;
        err_d  = 1'b1;
      end else if (req.rd) begin
        data_d = req.byte_acc ? {56'd0, mem[req.idx]} : rd_word;
      end
    end
  end

  // Control and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Memory write port; contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (st_en) begin
      if (req.byte_acc) begin
        mem[req.idx] <= storeData_MEM[7:0];
      end else begin
        for (int i = 0; i < 8; i++) begin
          mem[base_idx | AW'(i)] <= storeData_MEM[8*i +: 8];
        end
      end
    end
  end

  assign memDataOut = data_q;
  assign memErr     = err_q;

endmodule
